// File: rtl/bus_mux_n.sv
// Parametrised CPU-to-peripheral interconnect: base/mask decode, registered slave
// selection, read-data capture and bus error on unmapped or unacknowledged cycles.
module bus_mux_n #(
   parameter int NSLAVES = 4,
   parameter int AW      = 24,
   parameter int DW      = 16,
   parameter int SAW     = 8,
   parameter logic [NSLAVES*AW-1:0] SLAVE_BASE =
      {24'hF00200, 24'hF00100, 24'hF00000, 24'h000000},
   parameter logic [NSLAVES*AW-1:0] SLAVE_MASK =
      {24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hF00000},
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AW-1:0]          master_addr,
   input  logic [DW-1:0]          master_write,
   input  logic                   master_uds,
   input  logic                   master_lds,
   input  logic                   master_rw,
   output logic [DW-1:0]          master_read,
   output logic                   master_ack,
   output logic                   master_berr,
   output logic [DW-1:0]          slave_write,
   output logic [NSLAVES*SAW-1:0] slave_addr,
   output logic [NSLAVES-1:0]     slave_uds,
   output logic [NSLAVES-1:0]     slave_lds,
   output logic                   slave_rw,
   input  logic [NSLAVES*DW-1:0]  slave_read,
   input  logic [NSLAVES-1:0]     slave_ack
);
   localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                        r_state;
   logic [SELW-1:0]               r_sel;
   logic [CW-1:0]                 r_cnt;
   logic [DW-1:0]                 r_rdata;
   logic                          r_ack;
   logic                          r_berr;
   logic [DW-1:0]                 r_wdata;
   logic                          r_rw;
   logic [NSLAVES-1:0]            r_suds;
   logic [NSLAVES-1:0]            r_slds;
   logic [NSLAVES-1:0][SAW-1:0]   r_saddr;

   logic                          w_active;
   logic                          w_hit;
   logic [SELW-1:0]               w_dsel;
   logic                          w_sack;
   logic [DW-1:0]                 w_rd [NSLAVES];

   assign w_active = master_uds | master_lds;

   // Scan downward so the lowest matching index is the one left standing.
   always_comb begin
      w_hit  = 1'b0;
      w_dsel = '0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if ((master_addr & SLAVE_MASK[i*AW +: AW]) ==
             (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW])) begin
            w_hit  = 1'b1;
            w_dsel = SELW'(i);
         end
      end
   end

   for (genvar g = 0; g < NSLAVES; g++) begin : g_rd
      assign w_rd[g] = slave_read[g*DW +: DW];
   end

   assign w_sack = slave_ack[r_sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_berr  <= 1'b0;
         r_wdata <= '0;
         r_rw    <= 1'b1;
         r_suds  <= '0;
         r_slds  <= '0;
         r_saddr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_active) begin
                  r_rw    <= master_rw;
                  r_wdata <= master_write;
                  r_sel   <= w_dsel;
                  if (!w_hit) begin
                     r_berr  <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_suds[w_dsel]  <= master_uds;
                     r_slds[w_dsel]  <= master_lds;
                     r_saddr[w_dsel] <= master_addr[SAW-1:0];
                     r_cnt           <= '0;
                     r_state         <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               // Ack is tested before terminal count so a late ack still completes cleanly.
               if (!w_active) begin
                  r_suds  <= '0;
                  r_slds  <= '0;
                  r_saddr <= '0;
                  r_state <= S_IDLE;
               end else if (w_sack) begin
                  r_rdata <= w_rd[r_sel];
                  r_berr  <= 1'b0;
                  r_ack   <= 1'b1;
                  r_suds  <= '0;
                  r_slds  <= '0;
                  r_saddr <= '0;
                  r_state <= S_DONE;
               end else if (r_cnt == TC) begin
                  r_rdata <= '1;
                  r_berr  <= 1'b1;
                  r_ack   <= 1'b1;
                  r_suds  <= '0;
                  r_slds  <= '0;
                  r_saddr <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (!w_active) begin
                  r_ack   <= 1'b0;
                  r_berr  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign master_read = r_rdata;
   assign master_ack  = r_ack;
   assign master_berr = r_berr;
   assign slave_write = r_wdata;
   assign slave_rw    = r_rw;
   assign slave_uds   = r_suds;
   assign slave_lds   = r_slds;
   assign slave_addr  = r_saddr;

endmodule

// File: doc/bus_mux_n.md
# bus_mux_n

Parametrised bus interconnect between the single 68k-style CPU master and `NSLAVES` peripheral slaves (boot memory, UART, LEDs, SPI, and future devices). It is the successor to the fixed four-slave `device_mux`. It adds:
- a parameter-driven address map with base/mask compare per slave;
- registered slave selection;
- read-data capture;
- a bus-error response for unmapped addresses and for slaves that do not acknowledge within `TIMEOUT` cycles.

It sits between the CPU wrapper (`master_ack` drives `dtack` inverted) and the slave devices.

## Interface
- `NSLAVES`, 4: number of slave ports, range 1..16.
- `AW`, 24: master address width used for decode.
- `DW`, 16: data width.
- `SAW`, 8: slave-side address width. Slave address is `addr[SAW-1:0]`; slave 0 (memory) also uses `SAW`, so memory instances set `SAW = AW`.
- `SLAVE_BASE`, {24'hF00200, 24'hF00100, 24'hF00000, 24'h000000}: packed `NSLAVES*AW`; slice i is the base of slave i.
- `SLAVE_MASK`, {24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hF00000}: packed `NSLAVES*AW`; slice i is the compare mask of slave i.
- `TIMEOUT`, 255: cycles in ACCESS without slave ack before bus error, range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `master_addr`  in  AW  CPU address.
- `master_write`  in  DW  CPU write data.
- `master_uds`  in  1  upper byte strobe, active-high.
- `master_lds`  in  1  lower byte strobe, active-high.
- `master_rw`  in  1  1 = read, 0 = write.
- `master_read`  out  DW  registered read data to CPU.
- `master_ack`  out  1  cycle complete, active-high.
- `master_berr`  out  1  bus error, valid while `master_ack` = 1.
- `slave_write`  out  DW  write data, broadcast to all slaves.
- `slave_addr`  out  NSLAVES*SAW  per-slave address; non-selected slices are 0.
- `slave_uds`  out  NSLAVES  per-slave upper strobe.
- `slave_lds`  out  NSLAVES  per-slave lower strobe.
- `slave_rw`  out  1  latched rw, broadcast.
- `slave_read`  in  NSLAVES*DW  per-slave read data.
- `slave_ack`  in  NSLAVES  per-slave ack.

## Operation
- Decode: slave i matches when `(addr & MASK_i) == (BASE_i & MASK_i)`. The lowest matching index wins. No match means a miss.
- A cycle is active when `master_uds | master_lds` is high.
- IDLE:
  - On an active cycle, latch `addr`, `rw`, `uds`, `lds`, `write` and the decode result (`sel` and `miss`).
  - On a miss, go to DONE with `berr` = 1. Otherwise go to ACCESS.
- ACCESS:
  - Drive `slave_uds[sel]`, `slave_lds[sel]` and `slave_addr[sel]` from the latched values. All other slaves see strobes 0 and address 0.
  - When `slave_ack[sel]` = 1: capture `slave_read[sel]` into `master_read` (captured on writes too), set `berr` = 0, and go to DONE.
  - When the timeout counter reaches `TIMEOUT - 1` without an ack: set `master_read` = all-ones, set `berr` = 1, and go to DONE.
  - If the master drops both strobes (abort): go to IDLE with no ack.
- DONE:
  - `master_ack` = 1, `master_berr` = the latched `berr`, and all slave strobes = 0.
  - Hold until `master_uds` and `master_lds` are both 0, then go to IDLE and drop `master_ack` and `master_berr`.
- Acks from non-selected slaves are ignored in every state.
- A slave ack that arrives in the same cycle as the timeout wins: normal completion, `berr` = 0.
- The timeout counter is `clog2(TIMEOUT+1)` bits wide. It clears on entry to ACCESS and does not wrap, because it leaves ACCESS at terminal count.

## Timing
- Reset values:
  - State IDLE.
  - `master_read` = 0, `master_ack` = 0, `master_berr` = 0.
  - All `slave_uds` / `slave_lds` = 0, `slave_addr` = 0, `slave_write` = 0, `slave_rw` = 1.
  - Timeout counter = 0.
- Reset asserted mid-cycle forces the reset values on the next edge. The cycle is dropped with no ack.
- Latency:
  - Strobe seen at edge N: slave strobes are high after edge N+1.
  - Slave ack seen at edge M: `master_ack` and `master_read` are valid after edge M+1.
  - Zero-wait slave (ack combinational on strobe): `master_ack` is high 2 cycles after the strobe.
  - Miss: `master_ack` and `master_berr` are high 1 cycle after the strobe.
  - Timeout: `master_ack` is high `TIMEOUT + 1` cycles after the strobe.
- `master_ack` stays high for at least 1 cycle and until the strobes are released. A new cycle is accepted no earlier than the first edge in IDLE.
- Outputs are registered. There is no combinational path from master inputs to slave outputs, or from slave inputs to master outputs.

## Test plan
- Read from slave 1:
  - Stimulus: `addr` 0xF00004, uds = lds = 1, rw = 1; slave 1 acks after 3 cycles with 0x1234.
  - Required: only `slave_uds[1]` / `slave_lds[1]` high; `slave_addr[1]` = 0x04; `master_read` = 0x1234, ack = 1, berr = 0; ack drops one cycle after the strobes release.
- Byte write to slave 0:
  - Stimulus: `addr` 0x000011, lds only, rw = 0, data 0x00AB; slave 0 acks immediately.
  - Required: `slave_lds[0]` = 1, `slave_uds[0]` = 0; `slave_write` = 0x00AB; `slave_rw` = 0; `master_ack` 2 cycles after the strobe.
- Unmapped access:
  - Stimulus: `addr` 0xF00400.
  - Required: no slave strobe ever asserted; `master_ack` = 1 and `master_berr` = 1 one cycle after the strobe.
- Timeout:
  - Stimulus: `TIMEOUT` = 8; slave 3 (`addr` 0xF00200) never acks.
  - Required: ack and berr both high exactly 9 cycles after the strobe; `master_read` = 0xFFFF; `slave_uds[3]` / `slave_lds[3]` low in DONE.
- Ack at the timeout edge:
  - Stimulus: `TIMEOUT` = 8; slave acks on the terminal-count cycle with 0x5A5A.
  - Required: berr = 0 and `master_read` = 0x5A5A.
- Reset and abort:
  - Stimulus: assert reset during ACCESS; separately, drop the strobes during ACCESS.
  - Required: all outputs return to their reset values / IDLE with no ack. A subsequent read to slave 2 (`addr` 0xF00100) completes normally.
